// File: rtl/cal_pkg.sv
// Shared constants for the flag calculator and its condition evaluator.
//   - opcode constants for the arithmetic ops
//   - condition-code encodings (EQ..NV)
//   - bit positions of each flag in a {n,z,c,v} vector
package cal_pkg;

  localparam logic [2:0] OP_ADD = 3'b110;
  localparam logic [2:0] OP_SUB = 3'b111;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition decoder.
// Ports:
//   flags     in  4  status flags {n,z,c,v}
//   cond      in  4  condition code
//   cond_true out 1  condition holds for the given flags
module cond_eval
  import cal_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       cond_true
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      COND_EQ: cond_true = z;
      COND_NE: cond_true = ~z;
      COND_CS: cond_true = c;
      COND_CC: cond_true = ~c;
      COND_MI: cond_true = n;
      COND_PL: cond_true = ~n;
      COND_VS: cond_true = v;
      COND_VC: cond_true = ~v;
      COND_HI: cond_true = c & ~z;
      COND_LS: cond_true = ~c | z;
      COND_GE: cond_true = (n == v);
      COND_LT: cond_true = (n != v);
      COND_GT: cond_true = ~z & (n == v);
      COND_LE: cond_true = z | (n != v);
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/cal_flags_n.sv
// Registered N/Z/C/V flag calculator with per-flag update mask, one-stage valid
// pipeline, saturating overflow-event counter and a condition evaluator.
// Build option: CAL_FLAGS_STICKY_V_EN makes v sticky (set-only until clr/reset).
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   in_valid           inputs valid this cycle
//   op                 opcode; op[2:1]==2'b11 arithmetic, op[0] selects sub
//   result             ALU result (W bits)
//   co_add, cm_add     add carry-out / carry into MSB
//   co_sub, cm_sub     sub carry-out / carry into MSB (no-borrow sense)
//   upd_mask           per-flag write enable {N,Z,C,V}
//   clr                synchronous clear of flags and counter
//   cond               condition code to evaluate
//   out_valid          flags were updated by the previous cycle's valid input
//   n, z, c, v         registered flags
//   cond_true          condition evaluated on the registered flags
//   v_cnt              saturating overflow-event count (CNT_W bits)
module cal_flags_n
  import cal_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       op,
  input  logic [W-1:0]     result,
  input  logic             co_add,
  input  logic             cm_add,
  input  logic             co_sub,
  input  logic             cm_sub,
  input  logic [3:0]       upd_mask,
  input  logic             clr,
  input  logic [3:0]       cond,
  output logic             out_valid,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v,
  output logic             cond_true,
  output logic [CNT_W-1:0] v_cnt
);

  logic             arith, sel_co, sel_cm;
  logic [3:0]       flags_nx;
  logic [3:0]       flags_d, flags_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             ov_d, ov_q;

  assign arith  = (op[2:1] == OP_ADD[2:1]);
  assign sel_co = op[0] ? co_sub : co_add;
  assign sel_cm = op[0] ? cm_sub : cm_add;

  always_comb begin
    flags_nx         = '0;
    flags_nx[FLAG_N] = result[W-1];
    flags_nx[FLAG_Z] = (result == '0);
    flags_nx[FLAG_C] = arith & sel_co;
    flags_nx[FLAG_V] = arith & (sel_co ^ sel_cm);
  end

  always_comb begin
    flags_d = flags_q;
    cnt_d   = cnt_q;
    ov_d    = in_valid & ~clr;
    if (clr) begin
      flags_d = '0;
      cnt_d   = '0;
    end else if (in_valid) begin
      for (int i = 0; i < 4; i++) begin
        if (upd_mask[i]) flags_d[i] = flags_nx[i];
      end
`ifdef CAL_FLAGS_STICKY_V_EN
      // Sticky v: an update may set it but never clears it.
      flags_d[FLAG_V] = flags_q[FLAG_V] | (upd_mask[FLAG_V] & flags_nx[FLAG_V]);
`endif
      // flags_nx[FLAG_V] is already zero for non-arithmetic ops.
      if (upd_mask[FLAG_V] && flags_nx[FLAG_V] && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
    end
  end

  assign n         = flags_q[FLAG_N];
  assign z         = flags_q[FLAG_Z];
  assign c         = flags_q[FLAG_C];
  assign v         = flags_q[FLAG_V];
  assign out_valid = ov_q;
  assign v_cnt     = cnt_q;

  cond_eval u_cond_eval (
    .flags     (flags_q),
    .cond      (cond),
    .cond_true (cond_true)
  );

endmodule

// File: tb/tb_cal_flags_n.sv
// Self-checking bench for cal_flags_n (W=8, CNT_W=2) using a one-deep scoreboard.
module tb_cal_flags_n;

  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 2;

  logic             clk, reset, in_valid, co_add, cm_add, co_sub, cm_sub, clr;
  logic [2:0]       op;
  logic [W-1:0]     result;
  logic [3:0]       upd_mask, cond;
  logic             out_valid, n, z, c, v, cond_true;
  logic [CNT_W-1:0] v_cnt;

  cal_flags_n #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .op        (op),
    .result    (result),
    .co_add    (co_add),
    .cm_add    (cm_add),
    .co_sub    (co_sub),
    .cm_sub    (cm_sub),
    .upd_mask  (upd_mask),
    .clr       (clr),
    .cond      (cond),
    .out_valid (out_valid),
    .n         (n),
    .z         (z),
    .c         (c),
    .v         (v),
    .cond_true (cond_true),
    .v_cnt     (v_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             n, z, c, v, ov;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state
  logic             m_n, m_z, m_c, m_v;
  logic [CNT_W-1:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference condition: pairs of codes share a base term, bit 0 inverts it.
  function automatic logic ref_cond(input logic [3:0] cc, input logic fn, input logic fz,
                                    input logic fc, input logic fv);
    logic base;
    case (cc[3:1])
      3'd0:    base = fz;
      3'd1:    base = fc;
      3'd2:    base = fn;
      3'd3:    base = fv;
      3'd4:    base = fc && !fz;
      3'd5:    base = (fn == fv);
      3'd6:    base = !fz && (fn == fv);
      default: base = 1'b1;
    endcase
    return cc[0] ? !base : base;
  endfunction

  task automatic sweep_conds(input string tag);
    for (int i = 0; i < 16; i++) begin
      cond = 4'(i);
      #1;
      check($sformatf("%s_cond%0d", tag, i), {31'd0, cond_true},
            {31'd0, ref_cond(4'(i), m_n, m_z, m_c, m_v)});
    end
  endtask

  // Drive one cycle at the falling edge, push the expectation, compare after the rising edge.
  task automatic drive(input string tag, input logic [2:0] o, input logic [W-1:0] res,
                       input logic ca, input logic ma, input logic cs, input logic ms,
                       input logic [3:0] mask, input logic vld, input logic cl);
    logic arith, co, cm, vn;
    exp_t e, g;
    @(negedge clk);
    op = o; result = res; co_add = ca; cm_add = ma; co_sub = cs; cm_sub = ms;
    upd_mask = mask; in_valid = vld; clr = cl;
    arith = (o[2:1] == 2'b11);
    co    = o[0] ? cs : ca;
    cm    = o[0] ? ms : ma;
    vn    = arith && (co != cm);
    if (cl) begin
      {m_n, m_z, m_c, m_v} = 4'b0000;
      m_cnt = '0;
    end else if (vld) begin
      if (mask[3]) m_n = res[W-1];
      if (mask[2]) m_z = (res == '0);
      if (mask[1]) m_c = arith && co;
`ifdef CAL_FLAGS_STICKY_V_EN
      if (mask[0] && vn) m_v = 1'b1;
`else
      if (mask[0]) m_v = vn;
`endif
      if (mask[0] && vn && m_cnt != 2'b11) m_cnt = m_cnt + 2'd1;
    end
    e = '{n: m_n, z: m_z, c: m_c, v: m_v, ov: vld && !cl, cnt: m_cnt};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = '{n: n, z: z, c: c, v: v, ov: out_valid, cnt: v_cnt};
    if (exp_q.size() == 0) begin
      check({tag, "_sb"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_flags"}, {28'd0, g.n, g.z, g.c, g.v}, {28'd0, e.n, e.z, e.c, e.v});
      check({tag, "_ov"}, {31'd0, g.ov}, {31'd0, e.ov});
      check({tag, "_cnt"}, {30'd0, g.cnt}, {30'd0, e.cnt});
    end
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic model_reset();
    {m_n, m_z, m_c, m_v} = 4'b0000;
    m_cnt = '0;
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = 3'b000; result = '0; co_add = 1'b0; cm_add = 1'b0;
    co_sub = 1'b0; cm_sub = 1'b0; upd_mask = 4'h0; clr = 1'b0; cond = 4'd1;
    model_reset();
    #2;
    check("rst_flags", {28'd0, n, z, c, v}, 32'd0);
    check("rst_ov", {31'd0, out_valid}, 32'd0);
    check("rst_cnt", {30'd0, v_cnt}, 32'd0);
    check("rst_ne", {31'd0, cond_true}, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Overflowing add: n=1, v=1, c=0; LT must be false
    drive("add_ovf", 3'b110, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0);
    check("t2_v", {31'd0, v}, 32'd1);
    cond = 4'd11; #1;
    check("t2_lt", {31'd0, cond_true}, 32'd0);
    sweep_conds("t2");

    // Masked sub: only z loads
    drive("sub_zmask", 3'b111, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b0);
    check("t3_nzcv", {28'd0, n, z, c, v}, 32'b1101);
    check("t3_cnt", {30'd0, v_cnt}, 32'd1);

    // Load n, c, v with z held -> 1111
    drive("add_nc", 3'b110, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b0);
    check("all_set", {28'd0, n, z, c, v}, 32'hF);
    sweep_conds("all");

    // Asynchronous reset mid-cycle, with a valid pending
    in_valid = 1'b1; upd_mask = 4'hF;
    reset = 1'b1;
    #1;
    model_reset();
    cond = 4'd1;
    check("amid_flags", {28'd0, n, z, c, v}, 32'd0);
    check("amid_cnt", {30'd0, v_cnt}, 32'd0);
    check("amid_ne", {31'd0, cond_true}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Four overflowing adds back to back: counter 1,2,3,3
    for (int i = 0; i < 4; i++) begin
      drive($sformatf("sat%0d", i), 3'b110, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0);
    end
    check("sat_cnt", {30'd0, v_cnt}, 32'd3);

    // Idle cycle holds state, out_valid drops
    drive("idle", 3'b110, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0);

    // Non-arithmetic op clears c/v, sets z, no count
    drive("logic_op", 3'b010, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0);

    // Sub overflow: carry not inverted
    drive("sub_ovf", 3'b111, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0);

    // clr wins over an overflowing valid
    drive("clr_pri", 3'b110, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b1);
    check("t5_all", {27'd0, n, z, c, v, out_valid}, 32'd0);
    check("t5_cnt", {30'd0, v_cnt}, 32'd0);

    // Sticky-v behaviour
    drive("t6_ovf", 3'b110, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0);
    drive("t6_clean", 3'b110, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0);
`ifdef CAL_FLAGS_STICKY_V_EN
    check("t6_v", {31'd0, v}, 32'd1);
`else
    check("t6_v", {31'd0, v}, 32'd0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 40; i++) begin
      drive($sformatf("rnd%0d", i), 3'($urandom_range(7, 0)), 8'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            4'($urandom), ($urandom_range(3, 0) != 0), ($urandom_range(9, 0) == 0));
      if (i % 10 == 9) sweep_conds($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cal_flags_n.md
# cal_flags_n

Parametrised, registered successor to the team's 4-bit flag calculator. It computes the N/Z/C/V flags for a W-bit ALU result and holds them in a status register with a per-flag update mask, a one-stage valid pipeline, and a saturating overflow-event counter. A combinational condition evaluator reads the status register. The block sits between the ALU datapath and the control unit's branch logic.

## Interface
Parameters:
- W, 4: result width in bits (W ≥ 2)
- CNT_W, 8: overflow-event counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  result and flag inputs are valid this cycle
- op  in  3  opcode; op[2:1]==2'b11 is arithmetic, op[0]=0 add, op[0]=1 sub
- result  in  W  ALU result
- co_add, cm_add  in  1 each  add carry-out, and carry into the MSB
- co_sub, cm_sub  in  1 each  sub carry-out, and carry into the MSB
- upd_mask  in  4  per-flag write enable {N,Z,C,V}
- clr  in  1  synchronous clear of the flags and the counter
- cond  in  4  condition code to evaluate
- out_valid  out  1  flags updated by the previous cycle's valid input
- n, z, c, v  out  1 each  registered status flags
- cond_true  out  1  evaluated condition, from the registered flags
- v_cnt  out  CNT_W  saturating count of overflow events

## Operation
Next-flag computation (combinational, on the inputs):
- n_nx = result[W-1]
- z_nx = (result == 0)
- For arithmetic ops: c_nx = co_add (add) or co_sub (sub). v_nx = co^cm of the selected pair. The sub carry is not inverted (carry = no-borrow).
- For non-arithmetic ops: c_nx = 0, v_nx = 0.

Register update when in_valid=1 and clr=0:
- Each flag loads its next value only where its upd_mask bit is 1; masked flags hold.
- v_cnt increments when v_nx=1, upd_mask[0]=1, and the op is arithmetic. It saturates at all-ones and does not wrap.

Clear and hold:
- clr=1: flags and v_cnt go to 0, and out_valid goes to 0. clr has priority over in_valid.
- in_valid=0: all state holds.

cond_true, decoded from the registered flags:
- 0 EQ: z
- 1 NE: !z
- 2 CS: c
- 3 CC: !c
- 4 MI: n
- 5 PL: !n
- 6 VS: v
- 7 VC: !v
- 8 HI: c&!z
- 9 LS: !c|z
- 10 GE: n==v
- 11 LT: n!=v
- 12 GT: !z&(n==v)
- 13 LE: z|(n!=v)
- 14 AL: 1
- 15 NV: 0

## Timing
- Reset (asynchronous, active-high): n, z, c, v, out_valid and v_cnt are 0. cond_true follows from those values: EQ=0, NE=1, and so on.
- Latency: inputs sampled at edge k appear on the flags at edge k. out_valid=1 for exactly that cycle.
- out_valid is a registered copy of in_valid & !clr. Back-to-back valids are accepted every cycle; there is no stall.
- cond_true is combinational from the flag register and cond, with zero cycles from the flag update.
- Reset mid-stream clears everything immediately. The first valid after release updates normally.
- Counter at saturation with a further overflow event: v_cnt holds all-ones.

## Configuration
- CAL_FLAGS_STICKY_V_EN defined: v is sticky. An update sets v when v_nx=1 and otherwise holds it; only clr or reset clear v. upd_mask[0] still gates setting.
- Macro undefined: v is an ordinary masked load.
- v_cnt and cond_true behave identically in both builds.

## Structure
- Shared package cal_pkg holds:
  - the opcode constants (OP_ADD=3'b110, OP_SUB=3'b111)
  - the condition-code localparams (COND_EQ..COND_NV)
  - the flag-index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0)
- One sub-module, cond_eval: a combinational decoder taking {n,z,c,v} and cond and producing cond_true. It is reusable by the branch unit.

## Test plan
Run with W=8 and CNT_W=2 unless noted.
1. Reset asserted mid-stream, after flags were set to 4'b1111 → all outputs 0 asynchronously; cond=1 (NE) gives cond_true=1.
2. op=110, result=8'h80, co_add=0, cm_add=1, mask=4'hF, one valid → next cycle n=1, z=0, c=0, v=1, out_valid=1, v_cnt=1; cond=11 (LT) gives cond_true=0.
3. op=111, result=8'h00, co_sub=1, cm_sub=1, mask=4'b0100 → only z loads 1; n/c/v keep their prior values; v_cnt unchanged.
4. Four consecutive overflowing adds with CNT_W=2 → v_cnt reads 1, 2, 3, 3 (saturates).
5. in_valid=1 and clr=1 in the same cycle with an overflowing add → flags 0, v_cnt 0, out_valid 0.
6. Overflowing add, then a non-overflowing add with mask=4'hF:
   - With CAL_FLAGS_STICKY_V_EN: v stays 1.
   - Without it: v becomes 0.
